// File: rtl/hpm_snap_pkg.sv
// ----------------------------------------------------------------------------
// hpm_snap_pkg
// Shared definitions for the HPM snapshot unit: window FSM state encoding and
// the mcountinhibit CSR address/data values that open and close a window.
// ----------------------------------------------------------------------------
package hpm_snap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [31:0] INHIBIT_NONE      = 32'h0000_0000;
    localparam logic [31:0] INHIBIT_ALL       = 32'hFFFF_FFFF;

endpackage

// File: rtl/hpm_snap_fifo.sv
// ----------------------------------------------------------------------------
// hpm_snap_fifo
// Shift-style FIFO with a registered head: slot 0 is always the head entry,
// so rdata comes straight from a flop and stays stable until popped.
//
// Ports:
//   clk_h   in   clock
//   rst_h   in   asynchronous active-low reset (clears all slots and level)
//   push    in   write request; accepted when not full or when popping
//   wdata   in   WIDTH  entry to write
//   pop     in   remove head (ignored when empty)
//   rdata   out  WIDTH  head entry
//   full    out  DEPTH entries held
//   empty   out  no entries held
//   level   out  occupancy, $clog2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module hpm_snap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_h,
    input  logic             rst_h,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [LVL_W-1:0] level_q;
    logic             pop_ok;
    logic             push_ok;
    logic [PTR_W-1:0] wr_idx;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // When popping in the same cycle the contents shift down by one, so the
    // new entry lands one slot lower than the current occupancy.
    assign wr_idx = pop_ok ? PTR_W'(level_q - LVL_W'(1)) : PTR_W'(level_q);

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    slot_q[i] <= slot_q[i+1];
                end
                slot_q[DEPTH-1] <= '0;
            end
            if (push_ok) begin
                slot_q[wr_idx] <= wdata;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata = slot_q[0];
    assign level = level_q;

endmodule

// File: rtl/hpm_snapshot_unit.sv
// ----------------------------------------------------------------------------
// hpm_snapshot_unit
// Watches CSR writes to mcountinhibit. Clearing it opens a measurement
// window, setting it closes the window and queues a snapshot of the NUM_CH
// performance counters (plus target tag and sequence number) for the anomaly
// detector, which drains the queue over a valid/ready stream.
//
// Build option: define HPMSNAP_DELTA_EN to report per-window deltas
// (hpm_i - base, modulo 2^CNT_W); otherwise absolute counter values are
// reported and no base registers exist.
//
// Ports:
//   clk_h         in   clock
//   rst_h         in   asynchronous active-low reset
//   csr_we        in   CSR write strobe
//   csr_add       in   12   CSR address
//   csr_data      in   32   CSR write data
//   hpm_i         in   NUM_CH*CNT_W  live counters, channel ch at [ch*CNT_W +: CNT_W]
//   target        in   TAG_W  class tag, sampled in the stop cycle
//   snap_valid_o  out  FIFO head valid
//   snap_ready_i  in   detector accepts head
//   snap_data_o   out  NUM_CH*CNT_W  head payload
//   snap_tag_o    out  TAG_W  head tag
//   snap_seq_o    out  SEQ_W  head sequence number
//   win_active_o  out  window open
//   overflow_o    out  sticky: a snapshot was dropped
//   level_o       out  FIFO occupancy
// ----------------------------------------------------------------------------
module hpm_snapshot_unit
    import hpm_snap_pkg::*;
#(
    parameter int NUM_CH = 12,
    parameter int CNT_W  = 64,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 2,
    parameter int SEQ_W  = 16
) (
    input  logic                      clk_h,
    input  logic                      rst_h,
    input  logic                      csr_we,
    input  logic [11:0]               csr_add,
    input  logic [31:0]               csr_data,
    input  logic [NUM_CH*CNT_W-1:0]   hpm_i,
    input  logic [TAG_W-1:0]          target,
    output logic                      snap_valid_o,
    input  logic                      snap_ready_i,
    output logic [NUM_CH*CNT_W-1:0]   snap_data_o,
    output logic [TAG_W-1:0]          snap_tag_o,
    output logic [SEQ_W-1:0]          snap_seq_o,
    output logic                      win_active_o,
    output logic                      overflow_o,
    output logic [$clog2(DEPTH):0]    level_o
);

    localparam int PAY_W = NUM_CH * CNT_W;
    localparam int ENT_W = PAY_W + TAG_W + SEQ_W;

    state_t             state_q;
    state_t             state_d;
    logic               start_ev;
    logic               stop_ev;
    logic               vld_p0;
    logic [PAY_W-1:0]   payload_p0;
    logic               vld_p1;
    logic [ENT_W-1:0]   entry_p1;
    logic [SEQ_W-1:0]   seq_q;
    logic               ovf_q;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENT_W-1:0]   head;

    assign start_ev = csr_we & (csr_add == CSR_MCOUNTINHIBIT) & (csr_data == INHIBIT_NONE);
    assign stop_ev  = csr_we & (csr_add == CSR_MCOUNTINHIBIT) & (csr_data == INHIBIT_ALL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ev) state_d = ACTIVE;
            ACTIVE:  if (start_ev) state_d = ACTIVE;
                     else if (stop_ev) state_d = CAPTURE;
            CAPTURE: state_d = start_ev ? ACTIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p0: stop cycle, payload formed from this cycle's counters ----
    assign vld_p0 = (state_q == ACTIVE) & stop_ev;

`ifdef HPMSNAP_DELTA_EN
    logic [PAY_W-1:0] base_q;

    function automatic logic [CNT_W-1:0] cnt_delta(input logic [CNT_W-1:0] now,
                                                   input logic [CNT_W-1:0] base);
        // Unsigned modulo subtraction: a counter wrap inside the window still
        // yields the true elapsed count.
        return now - base;
    endfunction

    // Every start latches a fresh base, including re-base and a start that
    // arrives while the previous snapshot is being pushed.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            base_q <= '0;
        end else if (start_ev) begin
            base_q <= hpm_i;
        end
    end

    always_comb begin
        payload_p0 = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            payload_p0[ch*CNT_W +: CNT_W] = cnt_delta(hpm_i[ch*CNT_W +: CNT_W],
                                                      base_q[ch*CNT_W +: CNT_W]);
        end
    end
`else
    assign payload_p0 = hpm_i;
`endif

    // ---- stage p1: entry registered, pushed while the FSM sits in CAPTURE ----
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state_q  <= IDLE;
            vld_p1   <= 1'b0;
            entry_p1 <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= vld_p0;
            if (vld_p0) begin
                entry_p1 <= {payload_p0, target, seq_q};
                // Sequence advances for every closed window, even if its
                // snapshot ends up dropped, so gaps are visible downstream.
                seq_q    <= seq_q + SEQ_W'(1);
            end
            if (vld_p1 & fifo_full & ~pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign pop = ~fifo_empty & snap_ready_i;

    hpm_snap_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_h (clk_h),
        .rst_h (rst_h),
        .push  (vld_p1),
        .wdata (entry_p1),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign snap_valid_o = ~fifo_empty;
    assign snap_data_o  = head[ENT_W-1 -: PAY_W];
    assign snap_tag_o   = head[SEQ_W +: TAG_W];
    assign snap_seq_o   = head[SEQ_W-1:0];
    assign win_active_o = (state_q == ACTIVE);
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_hpm_snapshot_unit.sv
// ----------------------------------------------------------------------------
// tb_hpm_snapshot_unit
// Directed bench for hpm_snapshot_unit. A small reference model tracks the
// window base, sequence number and FIFO occupancy; expected snapshots are
// queued when a window is closed and compared when the DUT pops them.
// ----------------------------------------------------------------------------
module tb_hpm_snapshot_unit;
    import hpm_snap_pkg::*;

    localparam int NUM_CH = 12;
    localparam int CNT_W  = 64;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 2;
    localparam int SEQ_W  = 16;
    localparam int PAY_W  = NUM_CH * CNT_W;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

`ifdef HPMSNAP_DELTA_EN
    localparam logic [63:0] EXP_W1_CH2   = 64'd250;
    localparam logic [63:0] EXP_WRAP_CH0 = 64'd15;
    localparam logic [63:0] EXP_REB_CH2  = 64'd50;
`else
    localparam logic [63:0] EXP_W1_CH2   = 64'd350;
    localparam logic [63:0] EXP_WRAP_CH0 = 64'd5;
    localparam logic [63:0] EXP_REB_CH2  = 64'd90;
`endif

    logic               clk_h = 1'b0;
    logic               rst_h;
    logic               csr_we;
    logic [11:0]        csr_add;
    logic [31:0]        csr_data;
    logic [PAY_W-1:0]   hpm_i;
    logic [TAG_W-1:0]   target;
    logic               snap_valid_o;
    logic               snap_ready_i;
    logic [PAY_W-1:0]   snap_data_o;
    logic [TAG_W-1:0]   snap_tag_o;
    logic [SEQ_W-1:0]   snap_seq_o;
    logic               win_active_o;
    logic               overflow_o;
    logic [LVL_W-1:0]   level_o;

    always #5 clk_h = ~clk_h;

    hpm_snapshot_unit #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .SEQ_W  (SEQ_W)
    ) dut (
        .clk_h        (clk_h),
        .rst_h        (rst_h),
        .csr_we       (csr_we),
        .csr_add      (csr_add),
        .csr_data     (csr_data),
        .hpm_i        (hpm_i),
        .target       (target),
        .snap_valid_o (snap_valid_o),
        .snap_ready_i (snap_ready_i),
        .snap_data_o  (snap_data_o),
        .snap_tag_o   (snap_tag_o),
        .snap_seq_o   (snap_seq_o),
        .win_active_o (win_active_o),
        .overflow_o   (overflow_o),
        .level_o      (level_o)
    );

    typedef struct packed {
        logic [PAY_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic [SEQ_W-1:0] seq;
    } ent_t;

    ent_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [PAY_W-1:0] m_base;
    logic [SEQ_W-1:0] m_seq;
    int               m_level;
    bit               m_active;
    bit               m_ovf;

    task automatic chk_s(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [PAY_W-1:0] obs, input logic [PAY_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [CNT_W-1:0] v);
        hpm_i[ch*CNT_W +: CNT_W] = v;
    endtask

    function automatic logic [PAY_W-1:0] exp_payload();
        logic [PAY_W-1:0] r;
        r = hpm_i;
`ifdef HPMSNAP_DELTA_EN
        for (int ch = 0; ch < NUM_CH; ch++) begin
            r[ch*CNT_W +: CNT_W] = hpm_i[ch*CNT_W +: CNT_W] - m_base[ch*CNT_W +: CNT_W];
        end
`endif
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_base   = '0;
        m_seq    = '0;
        m_level  = 0;
        m_active = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic csr_pulse(input logic [11:0] addr, input logic [31:0] d);
        @(negedge clk_h);
        csr_we   = 1'b1;
        csr_add  = addr;
        csr_data = d;
        @(negedge clk_h);
        csr_we   = 1'b0;
        csr_data = '0;
    endtask

    task automatic start_win();
        m_base   = hpm_i;
        m_active = 1'b1;
        csr_pulse(CSR_MCOUNTINHIBIT, INHIBIT_NONE);
    endtask

    task automatic head_check(input string tag);
        ent_t e;
        chk_s({tag, "_valid"}, 64'(snap_valid_o), 64'(1'b1));
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q[0];
            chk_w({tag, "_data"}, snap_data_o, e.data);
            chk_s({tag, "_tag"}, 64'(snap_tag_o), 64'(e.tag));
            chk_s({tag, "_seq"}, 64'(snap_seq_o), 64'(e.seq));
        end
    endtask

    task automatic pop_check(input string tag);
        head_check(tag);
        snap_ready_i = 1'b1;
        @(negedge clk_h);
        snap_ready_i = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (m_level > 0) m_level--;
    endtask

    // Closes a window; with simul_pop the detector pops the full FIFO in the
    // very cycle the new snapshot is pushed.
    task automatic stop_win(input string tag, input bit simul_pop);
        ent_t e;
        e.data = exp_payload();
        e.tag  = target;
        e.seq  = m_seq;
        csr_pulse(CSR_MCOUNTINHIBIT, INHIBIT_ALL);
        chk_s({tag, "_win_low"}, 64'(win_active_o), 64'(1'b0));
        if (m_active) begin
            m_seq++;
            m_active = 1'b0;
            if (simul_pop) begin
                head_check({tag, "_popped"});
                snap_ready_i = 1'b1;
                @(negedge clk_h);
                snap_ready_i = 1'b0;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                exp_q.push_back(e);
            end else begin
                if (m_level < DEPTH) begin
                    exp_q.push_back(e);
                    m_level++;
                end else begin
                    m_ovf = 1'b1;
                end
                @(negedge clk_h);
            end
        end else begin
            @(negedge clk_h);
        end
        chk_s({tag, "_level"}, 64'(level_o), 64'(m_level));
        chk_s({tag, "_ovf"}, 64'(overflow_o), 64'(m_ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_h        = 1'b0;
        csr_we       = 1'b0;
        csr_add      = '0;
        csr_data     = '0;
        hpm_i        = '0;
        target       = '0;
        snap_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_h);

        chk_s("rst_valid", 64'(snap_valid_o), 64'(1'b0));
        chk_s("rst_level", 64'(level_o), 64'(0));
        chk_s("rst_ovf", 64'(overflow_o), 64'(1'b0));
        chk_s("rst_win", 64'(win_active_o), 64'(1'b0));
        chk_w("rst_data", snap_data_o, '0);
        chk_s("rst_tag", 64'(snap_tag_o), 64'(0));
        chk_s("rst_seq", 64'(snap_seq_o), 64'(0));
        rst_h = 1'b1;
        @(negedge clk_h);

        // Basic delta window
        set_ch(2, 64'd100);
        start_win();
        chk_s("w1_win_high", 64'(win_active_o), 64'(1'b1));
        set_ch(2, 64'd350);
        target = 2'd2;
        stop_win("w1", 1'b0);
        chk_s("w1_valid_lat", 64'(snap_valid_o), 64'(1'b1));
        chk_s("w1_ch2", snap_data_o[2*CNT_W +: CNT_W], EXP_W1_CH2);
        pop_check("w1");
        chk_s("w1_drained", 64'(snap_valid_o), 64'(1'b0));

        // Counter wrap inside a window
        set_ch(0, 64'hFFFF_FFFF_FFFF_FFF6);
        target = 2'd1;
        start_win();
        set_ch(0, 64'd5);
        stop_win("wrap", 1'b0);
        chk_s("wrap_ch0", snap_data_o[CNT_W-1:0], EXP_WRAP_CH0);
        pop_check("wrap");

        // Re-base: second start restarts the window
        set_ch(2, 64'd10);
        start_win();
        set_ch(2, 64'd40);
        start_win();
        chk_s("rebase_win", 64'(win_active_o), 64'(1'b1));
        set_ch(2, 64'd90);
        target = 2'd3;
        stop_win("rebase", 1'b0);
        chk_s("rebase_ch2", snap_data_o[2*CNT_W +: CNT_W], EXP_REB_CH2);
        pop_check("rebase");

        // Ignored events
        stop_win("idle_stop", 1'b0);
        chk_s("idle_stop_valid", 64'(snap_valid_o), 64'(1'b0));
        csr_pulse(CSR_MCOUNTINHIBIT, 32'h1);
        chk_s("odd_data_idle", 64'(win_active_o), 64'(1'b0));
        start_win();
        csr_pulse(CSR_MCOUNTINHIBIT, 32'h1);
        chk_s("odd_data_active", 64'(win_active_o), 64'(1'b1));
        csr_pulse(12'h321, INHIBIT_ALL);
        chk_s("other_addr", 64'(win_active_o), 64'(1'b1));
        set_ch(5, 64'd777);
        stop_win("after_ign", 1'b0);
        pop_check("after_ign");

        // Fill FIFO, then push while popping
        for (int i = 0; i < DEPTH; i++) begin
            set_ch(4, 64'(1000 + i));
            target = 2'(i);
            start_win();
            set_ch(4, 64'(1500 + 7 * i));
            stop_win("fill", 1'b0);
        end
        chk_s("fill_full", 64'(level_o), 64'(DEPTH));
        set_ch(4, 64'd3000);
        target = 2'd2;
        start_win();
        set_ch(4, 64'd3333);
        stop_win("simul", 1'b1);
        chk_s("simul_level", 64'(level_o), 64'(DEPTH));
        chk_s("simul_ovf", 64'(overflow_o), 64'(1'b0));
        for (int i = 0; i < DEPTH; i++) pop_check("simul_drain");
        chk_s("simul_empty", 64'(level_o), 64'(0));

        // Overflow from a fresh reset: five windows, no drain
        @(negedge clk_h);
        rst_h = 1'b0;
        model_reset();
        @(negedge clk_h);
        rst_h = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_ch(7, 64'(20 * i));
            target = 2'(i);
            start_win();
            set_ch(7, 64'(20 * i + 9 + i));
            stop_win("ovf", 1'b0);
        end
        chk_s("ovf_level", 64'(level_o), 64'(DEPTH));
        chk_s("ovf_flag", 64'(overflow_o), 64'(1'b1));
        chk_s("ovf_head_seq", 64'(snap_seq_o), 64'(0));
        pop_check("ovf_drain");
        pop_check("ovf_drain");
        chk_s("ovf_sticky", 64'(overflow_o), 64'(1'b1));
        chk_s("ovf_level2", 64'(level_o), 64'(2));

        // Reset mid-window with two entries queued
        start_win();
        @(posedge clk_h);
        #2;
        rst_h = 1'b0;
        #1;
        chk_s("midrst_valid", 64'(snap_valid_o), 64'(1'b0));
        chk_s("midrst_level", 64'(level_o), 64'(0));
        chk_s("midrst_win", 64'(win_active_o), 64'(1'b0));
        chk_s("midrst_ovf", 64'(overflow_o), 64'(1'b0));
        model_reset();
        @(negedge clk_h);
        rst_h = 1'b1;

        set_ch(9, 64'd42);
        target = 2'd1;
        start_win();
        set_ch(9, 64'd99);
        stop_win("post_rst", 1'b0);
        chk_s("post_rst_seq", 64'(snap_seq_o), 64'(0));
        pop_check("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
